fft_peak_detector: RTL and testbench

Consumes the 16-lane parallel output of the FFT and reports, once per frame, the bin with the largest magnitude. Each frame is FRAME_BEATS beats of 16 complex 13-bit bins. The block sits directly after the FFT module's valid_out/dout_re/dout_im outputs. Its result is a compact peak index and magnitude that can be probed or forwarded instead of the full 32-wire bus.

---
 rtl/fft_peak_detector_if.sv | 23 ++
 rtl/fft_peak_detector.sv | 153 +++++++++++++++
 tb/tb_fft_peak_detector.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fft_peak_detector_if.sv
// Beat bus from the FFT into the peak detector, plus the compact peak result.
// master = FFT-side producer / result consumer, slave = fft_peak_detector.
interface fft_peak_detector_if #(
  parameter int IDX_W = 9
);
  logic                    valid_in;
  logic signed [12:0]      din_re [16];
  logic signed [12:0]      din_im [16];
  logic                    peak_valid;
  logic [IDX_W-1:0]        peak_idx;
  logic [13:0]             peak_mag;
  logic [15:0]             frame_cnt;

  modport master (
    output valid_in, din_re, din_im,
    input  peak_valid, peak_idx, peak_mag, frame_cnt
  );

  modport slave (
    input  valid_in, din_re, din_im,
    output peak_valid, peak_idx, peak_mag, frame_cnt
  );
endinterface

// File: rtl/fft_peak_detector.sv
// Per-frame peak finder over 16-lane FFT beats: reports bin index and |re|+|im| of the maximum.
// Optional PEAK_SKIP_DC_EN: forces bin 0 to magnitude 0 so DC is never reported.
module fft_peak_detector #(
  parameter int FRAME_BEATS = 32,
  parameter int IDX_W       = 9
) (
  input  logic              clk,
  input  logic              rstn,
  fft_peak_detector_if.slave bus
);
  localparam int                  LANES     = 16;
  localparam int                  BEAT_W    = $clog2(FRAME_BEATS);
  localparam logic [BEAT_W-1:0]   LAST_BEAT = BEAT_W'(FRAME_BEATS - 1);

  // |re|+|im| in 14 bits; |-4096| = 4096 so the sum tops out at 8192.
  function automatic logic [13:0] lane_mag(input logic signed [12:0] re,
                                           input logic signed [12:0] im);
    logic signed [13:0] sre;
    logic signed [13:0] sim;
    logic [13:0]        a_re;
    logic [13:0]        a_im;
    sre  = {re[12], re};
    sim  = {im[12], im};
    a_re = sre[13] ? $unsigned(-sre) : $unsigned(sre);
    a_im = sim[13] ? $unsigned(-sim) : $unsigned(sim);
    return a_re + a_im;
  endfunction

  logic [BEAT_W-1:0] beat_cnt;

  logic              s1_valid;
  logic              s1_first;
  logic              s1_last;
  logic [BEAT_W-1:0] s1_beat;
  logic [13:0]       s1_mag [LANES];

  logic [13:0]       best_mag;
  logic [3:0]        best_lane;

  logic              s2_valid;
  logic              s2_first;
  logic              s2_last;
  logic [13:0]       s2_mag;
  logic [IDX_W-1:0]  s2_idx;

  logic              s3_done;
  logic [13:0]       run_mag;
  logic [IDX_W-1:0]  run_idx;

  logic              peak_valid;
  logic [IDX_W-1:0]  peak_idx;
  logic [13:0]       peak_mag;
  logic [15:0]       frame_cnt;

  // NOTE: non-blocking assignments in every clocked block so each stage samples the previous stage's old value.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      beat_cnt <= '0;
    end else if (bus.valid_in) begin
      beat_cnt <= (beat_cnt == LAST_BEAT) ? '0 : beat_cnt + 1'b1;
    end
  end

  // S1: lane magnitudes and frame position of the beat.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s1_valid <= 1'b0;
      s1_first <= 1'b0;
      s1_last  <= 1'b0;
      s1_beat  <= '0;
      for (int l = 0; l < LANES; l++) s1_mag[l] <= '0;
    end else begin
      s1_valid <= bus.valid_in;
      if (bus.valid_in) begin
        for (int l = 0; l < LANES; l++) s1_mag[l] <= lane_mag(bus.din_re[l], bus.din_im[l]);
`ifdef PEAK_SKIP_DC_EN
        if (beat_cnt == '0) s1_mag[0] <= '0;
`endif
        s1_beat  <= beat_cnt;
        s1_first <= (beat_cnt == '0);
        s1_last  <= (beat_cnt == LAST_BEAT);
      end
    end
  end

  // S2 select: strict '>' scanning upward keeps the lower lane on ties.
  // NOTE: defaults assigned before the loop keep this block free of latches.
  always_comb begin
    best_mag  = s1_mag[0];
    best_lane = '0;
    for (int l = 1; l < LANES; l++) begin
      if (s1_mag[l] > best_mag) begin
        best_mag  = s1_mag[l];
        best_lane = 4'(l);
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s2_valid <= 1'b0;
      s2_first <= 1'b0;
      s2_last  <= 1'b0;
      s2_mag   <= '0;
      s2_idx   <= '0;
    end else begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_first <= s1_first;
        s2_last  <= s1_last;
        s2_mag   <= best_mag;
        s2_idx   <= IDX_W'({s1_beat, best_lane});
      end
    end
  end

  // S3: running max; first beat reloads, later beats win only when strictly greater.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s3_done <= 1'b0;
      run_mag <= '0;
      run_idx <= '0;
    end else begin
      s3_done <= s2_valid && s2_last;
      if (s2_valid && (s2_first || (s2_mag > run_mag))) begin
        run_mag <= s2_mag;
        run_idx <= s2_idx;
      end
    end
  end

  // Result register: captures the finished frame while S3 reloads for the next one.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      peak_valid <= 1'b0;
      peak_idx   <= '0;
      peak_mag   <= '0;
      frame_cnt  <= '0;
    end else begin
      peak_valid <= s3_done;
      if (s3_done) begin
        peak_idx  <= run_idx;
        peak_mag  <= run_mag;
        frame_cnt <= frame_cnt + 16'd1;
      end
    end
  end

  assign bus.peak_valid = peak_valid;
  assign bus.peak_idx   = peak_idx;
  assign bus.peak_mag   = peak_mag;
  assign bus.frame_cnt  = frame_cnt;
endmodule

// File: tb/tb_fft_peak_detector.sv
// Directed bench for fft_peak_detector: frame-level model of expected peaks plus
// hand-computed literal expectations for each scenario.
module tb_fft_peak_detector;
  localparam int FRAME_BEATS = 32;
  localparam int IDX_W       = 9;
  localparam int BINS        = 16 * FRAME_BEATS;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  fft_peak_detector_if #(.IDX_W(IDX_W)) bus ();

  fft_peak_detector #(.FRAME_BEATS(FRAME_BEATS), .IDX_W(IDX_W)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus.slave)
  );

  typedef struct {
    int due;
    int idx;
    int mag;
    int cnt;
  } exp_t;

  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  exp_t exp_q[$];
  int   hold_idx = 0, hold_mag = 0, hold_cnt = 0;
  int   model_beat = 0, exp_frames = 0;
  int   fr_re[BINS], fr_im[BINS], acc_mag[BINS];
  int   pulse_cnt = 0, obs_idx = 0, obs_mag = 0, obs_cnt = 0, obs_edge = 0, last_edge = 0;
  int   obs_q[$];

  always @(posedge clk) cyc++;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  function automatic int bin_mag(input int bin, input int re, input int im);
    int m;
    m = iabs(re) + iabs(im);
`ifdef PEAK_SKIP_DC_EN
    if (bin == 0) m = 0;
`endif
    return m;
  endfunction

  // Compare process: every cycle out of reset, outputs must match the model's view.
  always @(negedge clk) begin
    if (rstn) begin
      automatic bit due = (exp_q.size() > 0) && (exp_q[0].due == cyc);
      if (due) begin
        automatic exp_t e = exp_q.pop_front();
        hold_idx = e.idx;
        hold_mag = e.mag;
        hold_cnt = e.cnt;
      end
      check("peak_valid", int'(bus.peak_valid), int'(due));
      check("peak_idx",   int'(bus.peak_idx),   hold_idx);
      check("peak_mag",   int'(bus.peak_mag),   hold_mag);
      check("frame_cnt",  int'(bus.frame_cnt),  hold_cnt);
      if (bus.peak_valid) begin
        pulse_cnt++;
        obs_idx  = int'(bus.peak_idx);
        obs_mag  = int'(bus.peak_mag);
        obs_cnt  = int'(bus.frame_cnt);
        obs_edge = cyc;
        obs_q.push_back(obs_idx);
      end
    end
  end

  task automatic clear_frame();
    for (int b = 0; b < BINS; b++) begin
      fr_re[b] = 0;
      fr_im[b] = 0;
    end
  endtask

  task automatic set_bin(input int bin, input int re, input int im);
    fr_re[bin] = re;
    fr_im[bin] = im;
  endtask

  // Drives stimulus beat 'beat'; the model numbers bins by its own beat count.
  task automatic drive_beat(input int beat);
    int best;
    @(negedge clk);
    bus.valid_in = 1'b1;
    for (int l = 0; l < 16; l++) begin
      bus.din_re[l] = 13'(fr_re[beat*16 + l]);
      bus.din_im[l] = 13'(fr_im[beat*16 + l]);
      acc_mag[model_beat*16 + l] = bin_mag(model_beat*16 + l, fr_re[beat*16 + l], fr_im[beat*16 + l]);
    end
    last_edge = cyc + 1;
    if (model_beat == FRAME_BEATS - 1) begin
      best = 0;
      for (int b = 1; b < BINS; b++) if (acc_mag[b] > acc_mag[best]) best = b;
      exp_frames = (exp_frames + 1) & 16'hffff;
      exp_q.push_back('{due: cyc + 4, idx: best, mag: acc_mag[best], cnt: exp_frames});
      model_beat = 0;
    end else begin
      model_beat++;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      bus.valid_in = 1'b0;
    end
  endtask

  task automatic send_frame(input bit gaps);
    for (int b = 0; b < FRAME_BEATS; b++) begin
      if (gaps && ($urandom_range(0, 2) == 0)) idle(int'($urandom_range(1, 3)));
      drive_beat(b);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rstn         = 1'b0;
    bus.valid_in = 1'b0;
    exp_q.delete();
    hold_idx   = 0;
    hold_mag   = 0;
    hold_cnt   = 0;
    model_beat = 0;
    exp_frames = 0;
    #1;
    check("rst_peak_valid", int'(bus.peak_valid), 0);
    check("rst_peak_idx",   int'(bus.peak_idx),   0);
    check("rst_peak_mag",   int'(bus.peak_mag),   0);
    check("rst_frame_cnt",  int'(bus.frame_cnt),  0);
    repeat (2) @(negedge clk);
    rstn      = 1'b1;
    pulse_cnt = 0;
    obs_q.delete();
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() > 0) && (n < 20)) begin
      @(negedge clk);
      bus.valid_in = 1'b0;
      n++;
    end
    idle(3);
    check("drain_pending", exp_q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int gap_last;
    bus.valid_in = 1'b0;
    for (int l = 0; l < 16; l++) begin
      bus.din_re[l] = '0;
      bus.din_im[l] = '0;
    end
    repeat (2) @(negedge clk);

    // 1: reset after beat 10 of a frame, then a clean frame peaking at bin 3.
    clear_frame();
    set_bin(50, 4000, 0);
    set_bin(3, 60, -40);
    do_reset();
    for (int b = 0; b <= 10; b++) drive_beat(b);
    do_reset();
    set_bin(50, 0, 0);
    send_frame(1'b0);
    idle(2);
    drain();
    check("t1_pulses", pulse_cnt, 1);
    check("t1_idx", obs_idx, 3);
    check("t1_mag", obs_mag, 100);
    check("t1_frame_cnt", obs_cnt, 1);

    // 2: single tone at bin 37.
    clear_frame();
    set_bin(37, 200, -50);
    do_reset();
    send_frame(1'b0);
    gap_last = last_edge;
    idle(2);
    drain();
    check("t2_idx", obs_idx, 37);
    check("t2_mag", obs_mag, 250);
    check("t2_frame_cnt", obs_cnt, 1);
    check("t2_latency", obs_edge - gap_last, 3);

    // 3: extreme negative corner in the last bin against small noise.
    clear_frame();
    for (int b = 0; b < BINS; b++)
      set_bin(b, int'($urandom_range(0, 100)) - 50, int'($urandom_range(0, 100)) - 50);
    set_bin(511, -4096, -4096);
    do_reset();
    send_frame(1'b0);
    idle(2);
    drain();
    check("t3_idx", obs_idx, 511);
    check("t3_mag", obs_mag, 8192);

    // 4a: equal magnitude in two beats; earlier bin wins.
    clear_frame();
    set_bin(20, 500, 0);
    set_bin(300, -250, 250);
    do_reset();
    send_frame(1'b0);
    idle(2);
    drain();
    check("t4a_idx", obs_idx, 20);
    check("t4a_mag", obs_mag, 500);

    // 4b: equal maximum on lanes 3 and 9 of beat 4; lower lane wins.
    clear_frame();
    set_bin(67, 700, 0);
    set_bin(73, 0, -700);
    set_bin(5, 100, 100);
    do_reset();
    send_frame(1'b0);
    idle(2);
    drain();
    check("t4b_idx", obs_idx, 67);
    check("t4b_mag", obs_mag, 700);

    // 5: three back-to-back frames, then one with random gaps.
    do_reset();
    clear_frame(); set_bin(1,   300, 0);   send_frame(1'b0);
    clear_frame(); set_bin(256, 0, 310);   send_frame(1'b0);
    clear_frame(); set_bin(100, -320, 5);  send_frame(1'b0);
    clear_frame(); set_bin(400, 150, -150); send_frame(1'b1);
    gap_last = last_edge;
    idle(2);
    drain();
    check("t5_pulses", pulse_cnt, 4);
    check("t5_obs_count", obs_q.size(), 4);
    if (obs_q.size() == 4) begin
      check("t5_idx0", obs_q[0], 1);
      check("t5_idx1", obs_q[1], 256);
      check("t5_idx2", obs_q[2], 100);
      check("t5_idx3", obs_q[3], 400);
    end
    check("t5_gap_latency", obs_edge - gap_last, 3);
    check("t5_frame_cnt", obs_cnt, 4);

    // 6: dominant DC bin versus a small bin 9.
    clear_frame();
    set_bin(0, 1000, 0);
    set_bin(9, 20, -20);
    do_reset();
    send_frame(1'b0);
    idle(2);
    drain();
`ifdef PEAK_SKIP_DC_EN
    check("t6_idx", obs_idx, 9);
    check("t6_mag", obs_mag, 40);
`else
    check("t6_idx", obs_idx, 0);
    check("t6_mag", obs_mag, 1000);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
